// File: rtl/fft_pipe_seq_ctrl_if.sv
// Handshake and sequencing signals between the FFT sequencing controller and its
// surrounding datapath/stream environment.
interface fft_pipe_seq_ctrl_if #(
   parameter int unsigned PIPE_DEPTH = 8,
   parameter int unsigned CNT_W      = 10
);
   logic                  in_valid;
   logic                  in_sof;
   logic                  in_ready;
   logic [CNT_W-1:0]      in_beat_idx;
   logic                  stage_en;
   logic [PIPE_DEPTH-1:0] stage_vld;
   logic                  out_valid;
   logic                  out_sof;
   logic                  out_eof;
   logic                  out_ready;
   logic                  frame_done;
   logic                  err_sof;

   // Environment side: drives the upstream beat and downstream ready.
   modport master (
      output in_valid, in_sof, out_ready,
      input  in_ready, in_beat_idx, stage_en, stage_vld, out_valid, out_sof, out_eof,
      input  frame_done, err_sof
   );

   // Controller side.
   modport slave (
      input  in_valid, in_sof, out_ready,
      output in_ready, in_beat_idx, stage_en, stage_vld, out_valid, out_sof, out_eof,
      output frame_done, err_sof
   );
endinterface

// File: rtl/fft_pipe_seq_ctrl.sv
// Sequencing controller for the radix-16 FFT pipeline: global stall/advance,
// per-stage valid flags, frame delimiting and twiddle beat index.
module fft_pipe_seq_ctrl #(
   parameter int unsigned PIPE_DEPTH      = 8,
   parameter int unsigned BEATS_PER_FRAME = 1024,
   parameter int unsigned CNT_W           = 10
) (
   input logic               clk,
   input logic               rst_n,
   fft_pipe_seq_ctrl_if.slave bus
);
   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS_PER_FRAME - 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic [PIPE_DEPTH-1:0] vld_q, sof_q, eof_q;
   logic                  done_q, err_q, err_d;
   logic                  stage_en, accept, keep, sof_tag, eof_tag, last_vld;

   // Whole pipeline stalls only when the last stage holds a beat nobody takes.
   assign last_vld = vld_q[PIPE_DEPTH-1];
   assign stage_en = bus.out_ready | ~last_vld;
   assign accept   = bus.in_valid & stage_en;

   assign bus.stage_en    = stage_en;
   assign bus.in_ready    = stage_en;
   assign bus.in_beat_idx = (state_q == StRun) ? beat_cnt_q : '0;
   assign bus.stage_vld   = vld_q;
   assign bus.out_valid   = last_vld;
   assign bus.out_sof     = sof_q[PIPE_DEPTH-1] & last_vld;
   assign bus.out_eof     = eof_q[PIPE_DEPTH-1] & last_vld;
   assign bus.frame_done  = done_q;
   assign bus.err_sof     = err_q;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      keep       = 1'b0;
      sof_tag    = 1'b0;
      eof_tag    = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (bus.in_sof) begin
                  keep       = 1'b1;
                  sof_tag    = 1'b1;
                  beat_cnt_d = CNT_W'(1);
                  state_d    = StRun;
               end else begin
                  // Stray beat outside a frame is consumed and dropped.
                  err_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (accept) begin
               keep  = 1'b1;
               err_d = bus.in_sof;
               if (beat_cnt_q == LastBeat) begin
                  eof_tag    = 1'b1;
                  beat_cnt_d = '0;
                  state_d    = StIdle;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         beat_cnt_q <= '0;
         vld_q      <= '0;
         sof_q      <= '0;
         eof_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
         done_q     <= last_vld & bus.out_ready & eof_q[PIPE_DEPTH-1];
         if (stage_en) begin
            vld_q <= {vld_q[PIPE_DEPTH-2:0], accept & keep};
            sof_q <= {sof_q[PIPE_DEPTH-2:0], sof_tag};
            eof_q <= {eof_q[PIPE_DEPTH-2:0], eof_tag};
         end
      end
   end
endmodule

// File: tb/tb_fft_pipe_seq_ctrl.sv
// Self-checking bench for fft_pipe_seq_ctrl: directed scenarios plus random
// valid/ready/sof traffic against a slot-array pipeline and frame-position model.
module tb_fft_pipe_seq_ctrl;
   localparam int PD  = 8;
   localparam int BPF = 1024;
   localparam int CW  = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fft_pipe_seq_ctrl_if #(.PIPE_DEPTH(PD), .CNT_W(CW)) bus ();

   fft_pipe_seq_ctrl #(.PIPE_DEPTH(PD), .BEATS_PER_FRAME(BPF), .CNT_W(CW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: PD slots (bubbles included) plus position within the current frame.
   logic m_vld[PD], m_sof[PD], m_eof[PD];
   logic m_in_frame, m_err_next, m_done_next;
   int   m_pos;

   int    cyc = 0;
   int    n_out, n_done, n_err, n_kept, first_acc_cyc, first_out_cyc, last_out_cyc;
   int    min_lat, max_lat, disc, disc_cyc;
   logic  first_out_sof;
   string disc_what;
   int    acc_cyc_q[$], sof_pos_q[$], eof_pos_q[$];

   function automatic void note(string what);
      if (disc == 0) begin
         disc_what = what;
         disc_cyc  = cyc;
      end
      disc++;
   endfunction

   task automatic clear_obs();
      n_out = 0; n_done = 0; n_err = 0; n_kept = 0;
      first_acc_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; first_out_sof = 1'b0;
      min_lat = 32'h7fff_ffff; max_lat = -1;
      disc = 0; disc_cyc = -1; disc_what = "";
      acc_cyc_q.delete(); sof_pos_q.delete(); eof_pos_q.delete();
   endtask

   task automatic model_reset();
      for (int i = 0; i < PD; i++) begin
         m_vld[i] = 1'b0; m_sof[i] = 1'b0; m_eof[i] = 1'b0;
      end
      m_in_frame = 1'b0; m_pos = 0; m_err_next = 1'b0; m_done_next = 1'b0;
      acc_cyc_q.delete();
   endtask

   // One clock: compare DUT against the model, log observations, advance both.
   task automatic tick(output logic accepted);
      logic          en, acc, keep, st, et, er;
      logic [PD-1:0] ev;
      logic [CW-1:0] eidx;
      int            lat;
      #1;
      for (int i = 0; i < PD; i++) ev[i] = m_vld[i];
      en   = bus.out_ready | ~m_vld[PD-1];
      eidx = m_in_frame ? CW'(m_pos) : '0;
      if (bus.stage_vld !== ev) note("stage_vld");
      if (bus.out_valid !== m_vld[PD-1]) note("out_valid");
      if (bus.out_sof !== (m_vld[PD-1] & m_sof[PD-1])) note("out_sof");
      if (bus.out_eof !== (m_vld[PD-1] & m_eof[PD-1])) note("out_eof");
      if (bus.stage_en !== en) note("stage_en");
      if (bus.in_ready !== en) note("in_ready");
      if (bus.in_beat_idx !== eidx) note("in_beat_idx");
      if (bus.err_sof !== m_err_next) note("err_sof");
      if (bus.frame_done !== m_done_next) note("frame_done");

      if (bus.out_valid === 1'b1 && first_out_cyc < 0) begin
         first_out_cyc = cyc;
         first_out_sof = bus.out_sof;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (bus.out_sof === 1'b1) sof_pos_q.push_back(n_out);
         if (bus.out_eof === 1'b1) eof_pos_q.push_back(n_out);
         if (acc_cyc_q.size() > 0) begin
            lat = cyc - acc_cyc_q.pop_front();
            if (lat < min_lat) min_lat = lat;
            if (lat > max_lat) max_lat = lat;
         end
         n_out++;
         last_out_cyc = cyc;
      end
      if (bus.frame_done === 1'b1) n_done++;
      if (bus.err_sof === 1'b1) n_err++;

      acc = bus.in_valid & en;
      keep = 1'b0; st = 1'b0; et = 1'b0; er = 1'b0;
      if (acc) begin
         if (!m_in_frame) begin
            if (bus.in_sof) begin
               keep = 1'b1; st = 1'b1; m_in_frame = 1'b1; m_pos = 1;
            end else begin
               er = 1'b1;
            end
         end else begin
            keep = 1'b1;
            er   = bus.in_sof;
            if (m_pos == BPF - 1) begin
               et = 1'b1; m_in_frame = 1'b0; m_pos = 0;
            end else begin
               m_pos++;
            end
         end
      end
      if (acc && keep) begin
         n_kept++;
         acc_cyc_q.push_back(cyc);
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      m_done_next = m_vld[PD-1] & bus.out_ready & m_eof[PD-1];
      m_err_next  = er;
      if (en) begin
         for (int i = PD - 1; i > 0; i--) begin
            m_vld[i] = m_vld[i-1]; m_sof[i] = m_sof[i-1]; m_eof[i] = m_eof[i-1];
         end
         m_vld[0] = acc & keep; m_sof[0] = st; m_eof[0] = et;
      end
      @(posedge clk);
      #1;
      cyc++;
      accepted = acc;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Push n accepted beats; sof asserted on beat indices sof_a / sof_b.
   task automatic send(input int n, input int sof_a, input int sof_b);
      logic a;
      int   k = 0;
      int   guard = 0;
      while (k < n && guard < 50 * n) begin
         bus.in_valid = 1'b1;
         bus.in_sof = (k == sof_a) || (k == sof_b);
         tick(a);
         if (a) k++;
         guard++;
      end
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      logic a;
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
      for (int i = 0; i < max_cycles && n_out < n_kept; i++) tick(a);
      tick(a);
      tick(a);
   endtask

   task automatic test_reset();
      bus.out_ready = 1'b0;
      do_reset();
      clear_obs();
      #1;
      n_checks++;
      if (bus.stage_vld !== '0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_vld: stage_vld=%b out_valid=%b, required 0/0", bus.stage_vld,
                  bus.out_valid);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.stage_en !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready=%b stage_en=%b, required 1/1", bus.in_ready,
                  bus.stage_en);
      end
      n_checks++;
      if (bus.in_beat_idx !== '0 || bus.frame_done !== 1'b0 || bus.err_sof !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_side: idx=%0d done=%b err=%b, required 0/0/0", bus.in_beat_idx,
                  bus.frame_done, bus.err_sof);
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_single_frame();
      int eof_at;
      do_reset();
      clear_obs();
      bus.out_ready = 1'b1;
      send(BPF, 0, -1);
      drain(64);
      eof_at = (eof_pos_q.size() > 0) ? eof_pos_q[0] : -1;
      n_checks++;
      if (first_out_cyc - first_acc_cyc !== PD || first_out_sof !== 1'b1) begin
         n_fail++;
         $display("FAIL single_latency: latency %0d sof %b, required %0d sof 1",
                  first_out_cyc - first_acc_cyc, first_out_sof, PD);
      end
      n_checks++;
      if (n_out !== BPF || sof_pos_q.size() !== 1) begin
         n_fail++;
         $display("FAIL single_count: beats %0d sofs %0d, required %0d and 1", n_out,
                  sof_pos_q.size(), BPF);
      end
      n_checks++;
      if (eof_pos_q.size() !== 1 || eof_at !== BPF - 1) begin
         n_fail++;
         $display("FAIL single_eof: %0d eofs first at %0d, required 1 at %0d",
                  eof_pos_q.size(), eof_at, BPF - 1);
      end
      n_checks++;
      if (n_done !== 1 || n_err !== 0) begin
         n_fail++;
         $display("FAIL single_done: done %0d err %0d, required 1 and 0", n_done, n_err);
      end
      n_checks++;
      if (disc !== 0) begin
         n_fail++;
         $display("FAIL single_model: %0d discrepancies (first %s at cycle %0d), required 0",
                  disc, disc_what, disc_cyc);
      end
   endtask

   task automatic test_back_to_back();
      int sof1;
      do_reset();
      clear_obs();
      bus.out_ready = 1'b1;
      send(2 * BPF, 0, BPF);
      drain(64);
      sof1 = (sof_pos_q.size() > 1) ? sof_pos_q[1] : -1;
      n_checks++;
      if (n_out !== 2 * BPF || last_out_cyc - first_out_cyc !== 2 * BPF - 1) begin
         n_fail++;
         $display("FAIL b2b_stream: beats %0d span %0d, required %0d and %0d", n_out,
                  last_out_cyc - first_out_cyc, 2 * BPF, 2 * BPF - 1);
      end
      n_checks++;
      if (sof_pos_q.size() !== 2 || sof1 !== BPF) begin
         n_fail++;
         $display("FAIL b2b_sof: %0d sofs second at %0d, required 2 at %0d",
                  sof_pos_q.size(), sof1, BPF);
      end
      n_checks++;
      if (n_done !== 2 || n_err !== 0 || disc !== 0) begin
         n_fail++;
         $display("FAIL b2b_done: done %0d err %0d disc %0d (%s), required 2/0/0", n_done,
                  n_err, disc, disc_what);
      end
   endtask

   task automatic test_backpressure();
      logic a;
      do_reset();
      clear_obs();
      bus.out_ready = 1'b1;
      send(20, 0, -1);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_sof = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (bus.stage_en !== 1'b0 || bus.in_ready !== 1'b0 || bus.stage_vld !== '1 ||
             bus.in_beat_idx !== CW'(20)) begin
            n_fail++;
            $display("FAIL bp_stall%0d: en=%b rdy=%b vld=%b idx=%0d, required 0/0/all-1/20", i,
                     bus.stage_en, bus.in_ready, bus.stage_vld, bus.in_beat_idx);
         end
         tick(a);
      end
      bus.out_ready = 1'b1;
      send(BPF - 20, -1, -1);
      drain(64);
      n_checks++;
      if (n_out !== BPF || n_done !== 1) begin
         n_fail++;
         $display("FAIL bp_count: beats %0d done %0d, required %0d and 1", n_out, n_done, BPF);
      end
      n_checks++;
      if (max_lat !== PD + 5 || min_lat !== PD) begin
         n_fail++;
         $display("FAIL bp_latency: max %0d min %0d, required %0d and %0d", max_lat, min_lat,
                  PD + 5, PD);
      end
      n_checks++;
      if (disc !== 0) begin
         n_fail++;
         $display("FAIL bp_model: %0d discrepancies (first %s at cycle %0d), required 0", disc,
                  disc_what, disc_cyc);
      end
   endtask

   task automatic test_framing_err();
      logic a;
      logic vld_seen = 1'b0;
      int   eof_at;
      do_reset();
      clear_obs();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = (i < 3);
         bus.in_sof = 1'b0;
         #1;
         if (bus.stage_vld !== '0) vld_seen = 1'b1;
         tick(a);
      end
      n_checks++;
      if (n_err !== 3 || vld_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL err_idle: err pulses %0d vld_seen %b, required 3 and 0", n_err,
                  vld_seen);
      end
      clear_obs();
      send(BPF, 0, 500);
      drain(64);
      eof_at = (eof_pos_q.size() > 0) ? eof_pos_q[0] : -1;
      n_checks++;
      if (n_err !== 1 || n_out !== BPF) begin
         n_fail++;
         $display("FAIL err_midsof: err %0d beats %0d, required 1 and %0d", n_err, n_out, BPF);
      end
      n_checks++;
      if (eof_at !== BPF - 1 || n_done !== 1 || disc !== 0) begin
         n_fail++;
         $display("FAIL err_frame: eof at %0d done %0d disc %0d (%s), required %0d/1/0",
                  eof_at, n_done, disc, disc_what, BPF - 1);
      end
   endtask

   task automatic test_bubbles();
      logic          a;
      logic [PD-1:0] pat;
      int            k = 0;
      int            eof_at;
      for (int i = 0; i < PD; i++) pat[i] = i[0];
      do_reset();
      clear_obs();
      bus.out_ready = 1'b1;
      for (int j = 0; j < 4 * BPF && k < BPF; j++) begin
         bus.in_valid = (j % 2 == 0);
         bus.in_sof = (k == 0) && (j % 2 == 0);
         if (j == 20) begin
            #1;
            n_checks++;
            if (bus.stage_vld !== pat && bus.stage_vld !== ~pat) begin
               n_fail++;
               $display("FAIL bubble_pattern: stage_vld=%b, required %b or %b", bus.stage_vld,
                        pat, ~pat);
            end
         end
         tick(a);
         if (a) k++;
      end
      drain(64);
      eof_at = (eof_pos_q.size() > 0) ? eof_pos_q[0] : -1;
      n_checks++;
      if (n_out !== BPF || eof_at !== BPF - 1 || n_done !== 1) begin
         n_fail++;
         $display("FAIL bubble_count: beats %0d eof at %0d done %0d, required %0d/%0d/1",
                  n_out, eof_at, n_done, BPF, BPF - 1);
      end
      n_checks++;
      if (max_lat !== PD || min_lat !== PD || disc !== 0) begin
         n_fail++;
         $display("FAIL bubble_order: lat %0d..%0d disc %0d (%s), required %0d and 0", min_lat,
                  max_lat, disc, disc_what, PD);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic a;
      do_reset();
      clear_obs();
      bus.out_ready = 1'b1;
      send(300, 0, -1);
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      model_reset();
      clear_obs();
      #1;
      n_checks++;
      if (bus.stage_vld !== '0 || bus.out_valid !== 1'b0 || bus.in_beat_idx !== '0) begin
         n_fail++;
         $display("FAIL midreset_clear: vld=%b out_valid=%b idx=%0d, required 0/0/0",
                  bus.stage_vld, bus.out_valid, bus.in_beat_idx);
      end
      bus.in_valid = 1'b1;
      bus.in_sof = 1'b0;
      tick(a);
      bus.in_valid = 1'b0;
      for (int i = 0; i < PD + 2; i++) tick(a);
      n_checks++;
      if (n_err !== 1 || n_out !== 0 || n_done !== 0 || disc !== 0) begin
         n_fail++;
         $display("FAIL midreset_idle: err %0d beats %0d done %0d disc %0d, required 1/0/0/0",
                  n_err, n_out, n_done, disc);
      end
   endtask

   task automatic test_random();
      logic a;
      do_reset();
      clear_obs();
      for (int i = 0; i < 5000; i++) begin
         bus.out_ready = ($urandom_range(0, 99) < 75);
         bus.in_valid = ($urandom_range(0, 99) < 80);
         bus.in_sof = m_in_frame ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 3) != 0);
         tick(a);
      end
      bus.out_ready = 1'b1;
      drain(64);
      n_checks++;
      if (n_out !== n_kept || n_done !== eof_pos_q.size()) begin
         n_fail++;
         $display("FAIL rand_count: out %0d kept %0d done %0d eofs %0d, required equal pairs",
                  n_out, n_kept, n_done, eof_pos_q.size());
      end
      n_checks++;
      if (disc !== 0) begin
         n_fail++;
         $display("FAIL rand_model: %0d discrepancies (first %s at cycle %0d), required 0",
                  disc, disc_what, disc_cyc);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_framing_err();
      test_bubbles();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end
endmodule
